// File: rtl/tx_frame_buffer.sv
// Store-and-forward TX frame buffer: words become readable only once a whole frame is held,
// or word-by-word (CUT) when a frame is longer than the buffer.
module tx_frame_buffer #(
  parameter int N     = 64,
  parameter int S     = 8,
  parameter int D     = N + S + 1,
  parameter int DEPTH = 64,
  parameter int AW    = 6
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [D-1:0]  write_pipe_data,
  input  logic          write_pipe_req,
  output logic          write_pipe_ack,
  output logic [D-1:0]  read_pipe_data,
  input  logic          read_pipe_req,
  output logic          read_pipe_ack,
  output logic [AW:0]   frame_count,
  output logic [AW:0]   occupancy
);

  typedef enum logic {HOLD, CUT} state_t;

  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

  state_t        state, state_nxt;
  logic [D-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [D-1:0]  head;
  logic          release_on, wr_en, rd_en, fc_inc, fc_dec;

  assign head       = mem[rd_ptr];
  assign release_on = (state == CUT);

  always_comb begin
    write_pipe_ack = (occupancy < FULL) && !reset;
    read_pipe_ack  = (occupancy != '0) && ((frame_count != '0) || release_on);
    read_pipe_data = read_pipe_ack ? head : '0;
    wr_en  = write_pipe_req && write_pipe_ack;
    rd_en  = read_pipe_req && read_pipe_ack;
    fc_inc = wr_en && write_pipe_data[D-1];
    // A cut-through frame may never have been counted; do not let the count underflow.
    fc_dec = rd_en && head[D-1] && !(release_on && (frame_count == '0));
  end

  always_comb begin
    state_nxt = state;
    case (state)
      HOLD: if ((occupancy == FULL) && (frame_count == '0)) state_nxt = CUT;
      CUT:  if (rd_en && head[D-1]) state_nxt = HOLD;
      default: state_nxt = HOLD;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= HOLD;
    else       state <= state_nxt;
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= write_pipe_data;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      occupancy   <= '0;
      frame_count <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (rd_en) rd_ptr <= rd_ptr + 1'b1;
      case ({wr_en, rd_en})
        2'b10:   occupancy <= occupancy + 1'b1;
        2'b01:   occupancy <= occupancy - 1'b1;
        default: occupancy <= occupancy;
      endcase
      case ({fc_inc, fc_dec})
        2'b10:   frame_count <= frame_count + 1'b1;
        2'b01:   frame_count <= frame_count - 1'b1;
        default: frame_count <= frame_count;
      endcase
    end
  end

endmodule

// File: tb/tb_tx_frame_buffer.sv
// Randomized bench for tx_frame_buffer against a queue-based model of held words and release mode.
module tb_tx_frame_buffer;
  localparam int D     = 73;
  localparam int DEPTH = 64;
  localparam int AW    = 6;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [D-1:0]  write_pipe_data = '0;
  logic          write_pipe_req = 1'b0;
  logic          write_pipe_ack;
  logic [D-1:0]  read_pipe_data;
  logic          read_pipe_req = 1'b0;
  logic          read_pipe_ack;
  logic [AW:0]   frame_count;
  logic [AW:0]   occupancy;

  tx_frame_buffer dut (
    .clk(clk), .reset(reset),
    .write_pipe_data(write_pipe_data), .write_pipe_req(write_pipe_req), .write_pipe_ack(write_pipe_ack),
    .read_pipe_data(read_pipe_data), .read_pipe_req(read_pipe_req), .read_pipe_ack(read_pipe_ack),
    .frame_count(frame_count), .occupancy(occupancy)
  );

  always #5 clk = ~clk;

  logic [D-1:0] q[$];     // words the buffer should hold, head first
  logic [D-1:0] pend[$];  // words the writer still has to send
  bit rel;                // model of forced release (oversized frame in flight)
  int total = 0;
  int bad = 0;
  int nrd = 0;            // reads observed on the DUT ports

  task automatic check(input string tag, input logic [D-1:0] got, input logic [D-1:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic int lasts();
    int n = 0;
    foreach (q[i]) n += int'(q[i][D-1]);
    return n;
  endfunction

  task automatic add_frame(input int len);
    logic [D-1:0] w;
    for (int i = 0; i < len; i++) begin
      w = {(i == len - 1), 8'($urandom), $urandom, $urandom};
      pend.push_back(w);
    end
  endtask

  // One clock: drive, compare against model, advance model on the edge. Entered/left at negedge.
  task automatic cyc(input int wp, input int rp);
    logic ew, er, w, r;
    logic [D-1:0] ed;
    int nl;
    write_pipe_req  = (pend.size() > 0) && ($urandom_range(99) < wp);
    write_pipe_data = (pend.size() > 0) ? pend[0] : '0;
    read_pipe_req   = $urandom_range(99) < rp;
    #1;
    nl = lasts();
    ew = q.size() < DEPTH;
    er = (q.size() > 0) && ((nl > 0) || rel);
    ed = er ? q[0] : '0;
    check("wr_ack", D'(write_pipe_ack), D'(ew));
    check("rd_ack", D'(read_pipe_ack), D'(er));
    check("rd_data", read_pipe_data, ed);
    check("occupancy", D'(occupancy), D'(q.size()));
    check("frame_count", D'(frame_count), D'(nl));
    if (read_pipe_req && read_pipe_ack) nrd++;
    w = write_pipe_req && ew;
    r = read_pipe_req && er;
    @(posedge clk);
    if (!rel && q.size() == DEPTH && nl == 0) rel = 1'b1;
    else if (rel && r && q[0][D-1]) rel = 1'b0;
    if (r) void'(q.pop_front());
    if (w) begin
      q.push_back(pend[0]);
      void'(pend.pop_front());
    end
    @(negedge clk);
  endtask

  task automatic drain(input int budget);
    int n = 0;
    while ((q.size() > 0 || pend.size() > 0) && n < budget) begin
      cyc(100, 100);
      n++;
    end
    check("drain_done", D'(occupancy), D'(0));
    check("drain_model", D'(q.size() + pend.size()), D'(0));
  endtask

  initial begin
    rel = 1'b0;
    @(negedge clk);
    #1;
    check("rst_wr_ack", D'(write_pipe_ack), D'(0));
    check("rst_rd_ack", D'(read_pipe_ack), D'(0));
    check("rst_occ", D'(occupancy), D'(0));
    @(negedge clk);
    reset = 1'b0;

    // 1: idle after reset
    for (int i = 0; i < 3; i++) cyc(0, 0);

    // 2: three-word frame held until complete, then read in order
    add_frame(3);
    for (int i = 0; i < 3; i++) cyc(100, 0);
    check("t2_ready", D'(read_pipe_ack), D'(1));
    nrd = 0;
    for (int i = 0; i < 4; i++) cyc(0, 100);
    check("t2_reads", D'(nrd), D'(3));

    // 3: oversized frame forces cut-through
    add_frame(70);
    nrd = 0;
    for (int i = 0; i < 200 && pend.size() + q.size() > 0; i++) cyc(100, 100);
    check("t3_reads", D'(nrd), D'(70));
    cyc(0, 100);

    // 4: write of B's last coincides with read of A's last
    add_frame(2);
    add_frame(1);
    pend[2][D-1] = 1'b0;
    for (int i = 0; i < 3; i++) cyc(100, 0);
    pend.push_back({1'b1, 8'hff, 64'h0123_4567_89ab_cdef});
    cyc(0, 100);
    cyc(100, 100);
    check("t4_occ", D'(occupancy), D'(2));
    check("t4_frames", D'(frame_count), D'(1));
    drain(50);

    // 5: fill with single-word frames, then free one entry
    for (int i = 0; i < DEPTH; i++) add_frame(1);
    for (int i = 0; i < DEPTH + 2; i++) cyc(100, 0);
    check("t5_full_ack", D'(write_pipe_ack), D'(0));
    check("t5_frames", D'(frame_count), D'(DEPTH));
    add_frame(1);
    cyc(0, 100);
    cyc(100, 0);
    drain(200);

    // 6: asynchronous reset mid-frame
    add_frame(8);
    for (int i = 0; i < 5; i++) cyc(100, 0);
    reset = 1'b1;
    #1;
    check("t6_occ", D'(occupancy), D'(0));
    check("t6_wr_ack", D'(write_pipe_ack), D'(0));
    check("t6_rd_ack", D'(read_pipe_ack), D'(0));
    q.delete();
    pend.delete();
    rel = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    add_frame(2);
    nrd = 0;
    for (int i = 0; i < 2; i++) cyc(100, 0);
    for (int i = 0; i < 4; i++) cyc(0, 100);
    check("t6_reads", D'(nrd), D'(2));

    // random traffic, occasionally with oversized frames
    for (int k = 0; k < 25; k++) begin
      for (int f = 0; f < 4; f++)
        add_frame(($urandom_range(9) == 0) ? int'($urandom_range(65, 90)) : int'($urandom_range(1, 12)));
      for (int i = 0; i < 150; i++) cyc(int'($urandom_range(30, 100)), int'($urandom_range(30, 100)));
    end
    drain(3000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
